motion_estimator: RTL and testbench
===================================

# motion_estimator

Integer-pel motion-estimation SAD engine for the H.264 inter-prediction path. It accepts one MACRO_DIM x MACRO_DIM current macroblock and a MACRO_DIM-row x SEARCH_DIM-column search strip from the reference picture, both streamed one column per cycle. It evaluates the sum of absolute differences (SAD) at every horizontal candidate offset and reports the minimum SAD with a one-cycle valid pulse. Vertical search and motion-vector bookkeeping live in the surrounding controller.

## Interface
- MACRO_DIM, 16, macroblock edge in pixels; also the column-vector length.
- SEARCH_DIM, 48, search-strip width in columns; number of candidates NC = SEARCH_DIM-MACRO_DIM+1 (33).
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-high (asserted = 1 resets on the clock edge).
- start  input  1  one-cycle request to begin a search; sampled only in IDLE.
- pixel_cpr_in  input  8 x MACRO_DIM  current-macroblock column; element k = row k.
- pixel_spr_in  input  8 x MACRO_DIM  search-strip column, columns 0..MACRO_DIM-1.
- pixel_spr_right_in  input  8 x MACRO_DIM  search-strip column, columns MACRO_DIM..SEARCH_DIM-1, shifted in from the right.
- valid  output  1  one-cycle pulse: min_sad holds a new result.
- min_sad  output  16  minimum SAD over all NC candidates, unsigned.

## Operation
- Storage: CUR[MACRO_DIM][MACRO_DIM] and WIN[MACRO_DIM][MACRO_DIM], both 8-bit. Best-SAD register BEST (16 bit). Column counter.
- FSM states:
  - IDLE: if start, set BEST = 16'hFFFF and counter = 0, then go to LOAD.
  - LOAD (MACRO_DIM cycles): each edge writes pixel_cpr_in into CUR column cnt and pixel_spr_in into WIN column cnt. After the last column, go to SEARCH.
  - SEARCH (NC cycles, candidate c = 0..NC-1):
    - Combinational SAD(c) = sum over all rows r and columns k of |CUR[r][k] - WIN[r][k]|.
    - Each edge: if SAD(c) < BEST then BEST = SAD(c). Strict less-than, so ties keep the earlier candidate.
    - For c < NC-1, WIN also shifts left one column and pixel_spr_right_in enters the rightmost column.
    - On c = NC-1, pixel_spr_right_in is ignored. The edge writes min_sad = min(BEST, SAD(NC-1)) and valid = 1, then goes to DONE.
  - DONE: one cycle. valid returns to 0 on the next edge, and the FSM returns to IDLE.
- Arithmetic:
  - Absolute difference: 8-bit unsigned.
  - Adder tree: widen to 16 bit. Maximum SAD 256*255 = 65280, so no overflow. No saturation.
- start outside IDLE is ignored. No queuing and no restart.
- Input columns are don't-care outside their sampling windows.

## Timing
- Call the edge where start is sampled in IDLE E0.
- pixel_cpr_in / pixel_spr_in are sampled at E1..E(MACRO_DIM), i.e. E1..E16.
- pixel_spr_right_in is sampled at E17..E(16+NC-1), i.e. E17..E48. Column MACRO_DIM+i arrives at E17+i.
- Candidate c is compared at E17+c. The final compare and result write happen at E(MACRO_DIM+NC) = E49.
- valid is high for exactly the cycle after E49. Latency from start to valid is 49 edges; the next start is accepted at E50 or later.
- min_sad holds its value until the next result write. It is not cleared by start.
- Reset values: valid = 0, min_sad = 0, BEST = 16'hFFFF, FSM = IDLE, CUR/WIN = 0.
- Reset asserted mid-operation aborts the search. No valid is produced, and min_sad returns to 0.
- Reset has priority over start on the same edge.

## Test plan
- Identical strips: CUR equals search columns 0..15, columns 16..47 = 0xFF, CUR pixels = 0x40 -> valid at E50 cycle, min_sad = 0.
- Constant offset: all CUR = 0x10, all search = 0x00 -> min_sad = 4096.
- Max difference: CUR = 0xFF, search = 0x00 -> min_sad = 65280, no wrap.
- Best at offset 20: search columns 20..35 = CUR pattern (pixel = row*16+col), other columns = 0x00 -> min_sad = 0.
  - Repeat with one pixel off by 3 at that offset -> min_sad = 3.
- Reset mid-search: assert rst_n at E30 -> valid never pulses, min_sad = 0. A fresh start afterwards completes normally with the correct result.
- start held high / pulsed during SEARCH -> ignored. Exactly one valid pulse at E49+1 per accepted start, with back-to-back start at E50 accepted.

Source files
------------

// File: rtl/motion_estimator_if.sv
// ============================================================================
// Module   : motion_estimator_if
// Brief    : Column-stream and result bus of the integer-pel SAD engine.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface motion_estimator_if #(
    parameter int MACRO_DIM = 16
);
    logic                     start;
    logic [8*MACRO_DIM-1:0]   pixel_cpr_in;
    logic [8*MACRO_DIM-1:0]   pixel_spr_in;
    logic [8*MACRO_DIM-1:0]   pixel_spr_right_in;
    logic                     valid;
    logic [15:0]              min_sad;

    modport master (
        output start, pixel_cpr_in, pixel_spr_in, pixel_spr_right_in,
        input  valid, min_sad
    );

    modport slave (
        input  start, pixel_cpr_in, pixel_spr_in, pixel_spr_right_in,
        output valid, min_sad
    );
endinterface

`default_nettype wire

// File: rtl/motion_estimator.sv
// ============================================================================
// Module   : motion_estimator
// Brief    : Horizontal full-search SAD engine; reports the minimum SAD.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module motion_estimator #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48
) (
    input  wire logic          clk,
    input  wire logic          rst_n,   // active-high synchronous reset
    motion_estimator_if.slave  bus
);
    localparam int NC    = SEARCH_DIM - MACRO_DIM + 1;
    localparam int IDX_W = $clog2(MACRO_DIM);
    localparam int CNT_W = $clog2(SEARCH_DIM);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_SEARCH = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_cur [MACRO_DIM][MACRO_DIM];
    logic [7:0]       r_win [MACRO_DIM][MACRO_DIM];
    logic [15:0]      r_best;
    logic [15:0]      r_min_sad;
    logic             r_valid;

    logic             w_init;
    logic             w_load;
    logic             w_search;
    logic             w_final;
    logic             w_load_last;
    logic [15:0]      w_sad;
    logic [15:0]      w_sad_min;

    function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    assign w_load_last = (r_cnt == CNT_W'(MACRO_DIM - 1));

    always_ff @(posedge clk) begin
        if (rst_n) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // DONE also honours start so a request on the edge after the result is accepted
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_nxt = S_LOAD;
            S_LOAD:   if (w_load_last) w_state_nxt = S_SEARCH;
            S_SEARCH: if (r_cnt == CNT_W'(NC - 1)) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = bus.start ? S_LOAD : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_init   = 1'b0;
        w_load   = 1'b0;
        w_search = 1'b0;
        w_final  = 1'b0;
        case (r_state)
            S_IDLE:   w_init = bus.start;
            S_LOAD:   w_load = 1'b1;
            S_SEARCH: begin
                w_search = 1'b1;
                w_final  = (r_cnt == CNT_W'(NC - 1));
            end
            S_DONE:   w_init = bus.start;
            default:  w_init = 1'b0;
        endcase
    end

    always_comb begin
        w_sad = 16'd0;
        for (int r = 0; r < MACRO_DIM; r++) begin
            for (int k = 0; k < MACRO_DIM; k++) begin
                w_sad = w_sad + {8'd0, absdiff(r_cur[r][k], r_win[r][k])};
            end
        end
    end

    assign w_sad_min = (w_sad < r_best) ? w_sad : r_best;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_cnt     <= '0;
            r_best    <= 16'hFFFF;
            r_min_sad <= 16'd0;
            r_valid   <= 1'b0;
            for (int r = 0; r < MACRO_DIM; r++) begin
                for (int k = 0; k < MACRO_DIM; k++) begin
                    r_cur[r][k] <= 8'd0;
                    r_win[r][k] <= 8'd0;
                end
            end
        end else begin
            r_valid <= w_final;
            if (w_init) begin
                r_best <= 16'hFFFF;
                r_cnt  <= '0;
            end
            if (w_load) begin
                for (int r = 0; r < MACRO_DIM; r++) begin
                    r_cur[r][r_cnt[IDX_W-1:0]] <= bus.pixel_cpr_in[8*r +: 8];
                    r_win[r][r_cnt[IDX_W-1:0]] <= bus.pixel_spr_in[8*r +: 8];
                end
                r_cnt <= w_load_last ? '0 : r_cnt + 1'b1;
            end
            if (w_search) begin
                r_best <= w_sad_min;
                r_cnt  <= r_cnt + 1'b1;
                if (w_final) begin
                    r_min_sad <= w_sad_min;
                end else begin
                    for (int r = 0; r < MACRO_DIM; r++) begin
                        for (int k = 0; k < MACRO_DIM - 1; k++) begin
                            r_win[r][k] <= r_win[r][k+1];
                        end
                        r_win[r][MACRO_DIM-1] <= bus.pixel_spr_right_in[8*r +: 8];
                    end
                end
            end
        end
    end

    assign bus.valid   = r_valid;
    assign bus.min_sad = r_min_sad;

endmodule

`default_nettype wire

// File: tb/tb_motion_estimator.sv
// ============================================================================
// Module   : tb_motion_estimator
// Brief    : Directed and random stimulus against a full-search SAD model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_motion_estimator;
    localparam int MD = 16;
    localparam int SD = 48;
    localparam int NC = SD - MD + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    motion_estimator_if #(.MACRO_DIM(MD)) bus ();

    motion_estimator #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) dut (
        .clk   (clk),
        .rst_n (rst),
        .bus   (bus.slave)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] cur   [MD][MD];
    logic [7:0] strip [MD][SD];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_min_sad();
        int best = 32'h7FFFFFFF;
        for (int c = 0; c < NC; c++) begin
            int s = 0;
            for (int r = 0; r < MD; r++) begin
                for (int k = 0; k < MD; k++) begin
                    int d = int'(cur[r][k]) - int'(strip[r][c+k]);
                    s += (d < 0) ? -d : d;
                end
            end
            if (s < best) best = s;
        end
        return best;
    endfunction

    function automatic logic [8*MD-1:0] rand_col();
        logic [8*MD-1:0] v;
        for (int r = 0; r < MD; r++) v[8*r +: 8] = 8'($urandom);
        return v;
    endfunction

    // Drive inputs for edge E<e>; columns outside their window get garbage.
    task automatic drive_step(input int e, input bit hold_start);
        bus.pixel_cpr_in       = rand_col();
        bus.pixel_spr_in       = rand_col();
        bus.pixel_spr_right_in = rand_col();
        for (int r = 0; r < MD; r++) begin
            if (e <= MD) begin
                bus.pixel_cpr_in[8*r +: 8] = cur[r][e-1];
                bus.pixel_spr_in[8*r +: 8] = strip[r][e-1];
            end else if (e <= MD + NC - 1) begin
                bus.pixel_spr_right_in[8*r +: 8] = strip[r][e-1];
            end
        end
        bus.start = hold_start && (e >= MD + 1) && (e <= MD + NC - 2);
    endtask

    // Starts at a negedge, returns at the negedge after the result edge.
    task automatic run_search(input string tag, input bit hold_start);
        int exp_sad     = ref_min_sad();
        logic [15:0] prev = bus.min_sad;
        int early       = 0;
        int drift       = 0;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int e = 1; e <= MD + NC; e++) begin
            drive_step(e, hold_start);
            @(posedge clk);
            @(negedge clk);
            if (e < MD + NC) begin
                if (bus.valid !== 1'b0) early++;
                if (bus.min_sad !== prev) drift++;
            end
        end
        bus.start = 1'b0;
        check({tag, "_early_valid"}, early, 0);
        check({tag, "_hold_min"}, drift, 0);
        check({tag, "_valid"}, {31'd0, bus.valid}, 1);
        check({tag, "_min_sad"}, {16'd0, bus.min_sad}, exp_sad);
    endtask

    task automatic fill(input logic [7:0] cv, input logic [7:0] sv);
        for (int r = 0; r < MD; r++) begin
            for (int k = 0; k < MD; k++) cur[r][k] = cv;
            for (int k = 0; k < SD; k++) strip[r][k] = sv;
        end
    endtask

    initial begin
        int vcount;
        int off;
        logic [15:0] held;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.pixel_cpr_in       = '0;
        bus.pixel_spr_in       = '0;
        bus.pixel_spr_right_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid", {31'd0, bus.valid}, 0);
        check("rst_min_sad", {16'd0, bus.min_sad}, 0);

        fill(8'h40, 8'hFF);
        for (int r = 0; r < MD; r++) for (int k = 0; k < MD; k++) strip[r][k] = 8'h40;
        run_search("identical", 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("valid_one_cycle", {31'd0, bus.valid}, 0);
        check("min_sad_hold", {16'd0, bus.min_sad}, 0);

        fill(8'h10, 8'h00);
        run_search("const_offset", 1'b0);
        fill(8'hFF, 8'h00);
        run_search("max_diff", 1'b1);

        fill(8'h00, 8'h00);
        for (int r = 0; r < MD; r++) begin
            for (int k = 0; k < MD; k++) begin
                cur[r][k]        = 8'(r * 16 + k);
                strip[r][20 + k] = 8'(r * 16 + k);
            end
        end
        run_search("offset20", 1'b0);
        strip[5][27] = cur[5][7] + 8'd3;
        run_search("offset20_off3", 1'b0);

        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < MD; r++) begin
                for (int k = 0; k < MD; k++) cur[r][k] = 8'($urandom);
                for (int k = 0; k < SD; k++) strip[r][k] = 8'($urandom);
            end
            off = int'($urandom_range(0, NC - 1));
            if (t != 0) begin
                for (int r = 0; r < MD; r++)
                    for (int k = 0; k < MD; k++)
                        strip[r][off + k] = cur[r][k] ^ 8'($urandom_range(0, 3));
            end
            run_search($sformatf("random%0d", t), t == 1);
        end

        // Abort at E30, with start presented on the last reset edge.
        held = bus.min_sad;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int e = 1; e < 30; e++) begin
            drive_step(e, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_min_sad", {16'd0, bus.min_sad}, 0);
        check("abort_valid", {31'd0, bus.valid}, 0);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        vcount    = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.valid !== 1'b0) vcount++;
        end
        check("abort_no_valid", vcount, 0);
        check("abort_min_sad_after", {16'd0, bus.min_sad}, 0);

        fill(8'h10, 8'h00);
        for (int r = 0; r < MD; r++) for (int k = 0; k < MD; k++) strip[r][33 + k] = 8'h12;
        run_search("fresh_after_abort", 1'b0);
        fill(8'h03, 8'h01);
        run_search("back_to_back", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

`default_nettype wire
